// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit bridging the MEM stage to a handshaked data memory
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [1:0] a_lo, sz;
  logic uns, wr;
  logic take, bad, accept, expire;
  logic [3:0] be_n;
  logic [31:0] wd_n, ld_n;
  logic [7:0] lb;
  logic [15:0] lh;
  // the cycle carrying a timeout pulse lets the stalled op retire, so it is not re-accepted
  assign take = state == IDLE && op_valid && !timeout_err;
  assign bad = op_size == 2'b11 || (op_size == 2'b01 && op_addr[0]) || (op_size == 2'b10 && op_addr[1:0] != 2'b00);
  assign accept = take && !bad;
  assign expire = state == BUSY && !mem_ack && cnt == CW'(ACK_TIMEOUT - 1);
  assign stall = !reset && (accept || state == BUSY);
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // next state: ack beats a same-cycle timeout
  always_comb begin
    next = state;
    next = state == IDLE ? (accept ? BUSY : IDLE) :
           state == BUSY ? (mem_ack ? DONE : expire ? IDLE : BUSY) : IDLE;
  end
  // lane steering for the request and lane extraction for the load result
  always_comb begin
    be_n = op_size == 2'b00 ? 4'b0001 << op_addr[1:0] :
           op_size == 2'b01 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_n = !op_write ? 32'd0 : op_size == 2'b00 ? {4{op_wdata[7:0]}} :
           op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
    lb = mem_rdata[{a_lo, 3'b000} +: 8];
    lh = a_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_n = wr ? 32'd0 : sz == 2'b00 ? {{24{lb[7] & !uns}}, lb} :
           sz == 2'b01 ? {{16{lh[15] & !uns}}, lh} : mem_rdata;
  end
  // request registers, pulses, ack timer and captured load data
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
      timeout_err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      cnt <= '0;
      a_lo <= '0;
      sz <= '0;
      uns <= 1'b0;
      wr <= 1'b0;
    end else begin
      addr_err <= take && bad;
      timeout_err <= expire;
      if (accept) begin
        mem_req <= 1'b1;
        mem_we <= op_write;
        mem_addr <= {op_addr[31:2], 2'b00};
        mem_be <= be_n;
        mem_wdata <= wd_n;
        cnt <= '0;
        a_lo <= op_addr[1:0];
        sz <= op_size;
        uns <= op_unsigned;
        wr <= op_write;
      end else if (state == BUSY) begin
        if (mem_ack || expire) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
        end
        if (mem_ack) rdata <= ld_n;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
